// File: rtl/shiftin.sv
// Serial-in reader for a parallel-in/serial-out chain (74HC165 style):
// pulses the active-low load, clocks WIDTH bits in MSB first, then presents the word.
module shiftin #(
  parameter int WIDTH = 16,
  parameter int HALF  = 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic             data_in,
  output logic             clk_out,
  output logic             load_out,
  output logic [WIDTH-1:0] bits_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_phase;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_sr;
  logic             w_phase_end;

  assign w_phase_end = (r_phase == PW'(HALF - 1));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_bitcnt <= '0;
      r_sr     <= '0;
      clk_out  <= 1'b0;
      load_out <= 1'b1;
      bits_out <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          clk_out  <= 1'b0;
          load_out <= 1'b1;
          busy_out <= 1'b0;
          r_phase  <= '0;
          if (start_in) begin
            r_state  <= S_LOAD;
            load_out <= 1'b0;
            busy_out <= 1'b1;
            r_bitcnt <= '0;
          end
        end
        S_LOAD: begin
          if (w_phase_end) begin
            r_phase  <= '0;
            r_state  <= S_LOW;
            load_out <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            r_phase <= '0;
            if (r_bitcnt < BW'(WIDTH)) begin
              // data_in is captured on the same edge that raises clk_out,
              // so the value seen is the one present before the rise.
              r_state  <= S_HIGH;
              clk_out  <= 1'b1;
              r_sr     <= {r_sr[WIDTH-2:0], data_in};
              r_bitcnt <= r_bitcnt + 1'b1;
            end else begin
              r_state  <= S_DONE;
              bits_out <= r_sr;
              done_out <= 1'b1;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            r_phase <= '0;
            r_state <= S_LOW;
            clk_out <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_phase  <= '0;
          busy_out <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftin.sv
// Bench for shiftin: two instances (16x1 and 8x3) fed by behavioural 74HC165 chains,
// checked every cycle against a timing model derived from the transfer schedule.
module tb_shiftin;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [15:0] pa;
  logic [7:0]  pb;
  logic        da, db;
  logic        coa, loa, ba, dna;
  logic        cob, lob, bb, dnb;
  logic [15:0] bia;
  logic [7:0]  bib;

  shiftin u_a (
    .clk_in(clk), .reset_in(rst), .start_in(start), .data_in(da),
    .clk_out(coa), .load_out(loa), .bits_out(bia), .busy_out(ba), .done_out(dna)
  );

  shiftin #(.WIDTH(8), .HALF(3)) u_b (
    .clk_in(clk), .reset_in(rst), .start_in(start), .data_in(db),
    .clk_out(cob), .load_out(lob), .bits_out(bib), .busy_out(bb), .done_out(dnb)
  );

  // 74HC165 chains: parallel load while PL low, shift toward QH on each clock rise.
  logic [15:0] qa = '0;
  logic [7:0]  qb = '0;
  always @(posedge coa or negedge loa)
    if (!loa) qa <= pa; else qa <= {qa[14:0], 1'b0};
  always @(posedge cob or negedge lob)
    if (!lob) qb <= pb; else qb <= {qb[6:0], 1'b0};
  assign da = qa[15];
  assign db = qb[7];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          wp[2] = '{16, 8};
  int          hp[2] = '{1, 3};
  bit          act[2];
  int          tst[2];
  logic [31:0] word[2];
  logic [31:0] ebits[2];
  int          rises[2];
  logic        pclk[2];

  // Observations after edge e are the values of cycle e+1 relative to the run.
  task automatic model_and_check(input int id, input int e, input logic co, input logic lo,
                                 input logic bu, input logic dn, input logic [31:0] bi,
                                 input logic [31:0] par);
    int T, c, ph;
    logic ec, el, eb, ed;
    T = (2 * wp[id] + 2) * hp[id] + 1;
    if (rst) begin
      act[id]   = 1'b0;
      ebits[id] = '0;
    end else if (start && (!act[id] || e >= tst[id] + T + 1)) begin
      act[id]   = 1'b1;
      tst[id]   = e;
      word[id]  = par;
      rises[id] = 0;
    end
    c  = e + 1 - tst[id];
    ec = 1'b0; el = 1'b1; eb = 1'b0; ed = 1'b0;
    if (act[id] && c >= 1 && c <= T) begin
      ph = (c - 1) / hp[id];
      eb = 1'b1;
      el = (ph != 0);
      ec = (ph >= 2) && (ph % 2 == 0) && (ph < 2 * wp[id] + 2);
      ed = (c == T);
    end
    if (ed) ebits[id] = word[id];
    if (co === 1'b1 && pclk[id] !== 1'b1) rises[id]++;
    pclk[id] = co;
    chk($sformatf("u%0d e%0d clk_out", id, e), {31'd0, co}, {31'd0, ec});
    chk($sformatf("u%0d e%0d load_out", id, e), {31'd0, lo}, {31'd0, el});
    chk($sformatf("u%0d e%0d busy_out", id, e), {31'd0, bu}, {31'd0, eb});
    chk($sformatf("u%0d e%0d done_out", id, e), {31'd0, dn}, {31'd0, ed});
    chk($sformatf("u%0d e%0d bits_out", id, e), bi, ebits[id]);
    if (ed) chk($sformatf("u%0d e%0d clk rises", id, e), rises[id], wp[id]);
  endtask

  // Stimulus sampled at edge n.
  task automatic set_stim(input int n);
    bit rr, rs;
    rr = ($urandom_range(0, 150) == 0);
    rs = ($urandom_range(0, 5) == 0);
    rst   = (n < 3) || (n == 142) || (n == 200) || (n >= 330 && rr);
    start = (n == 5) || (n == 10) || (n == 40) || (n == 70) || (n == 130) ||
            (n == 150) || (n == 200) || (n >= 220 && n < 320) || (n >= 330 && rs);
    if (n == 60) pa = 16'hAA00;
    if (n >= 330) begin
      pa = 16'($urandom);
      pb = 8'($urandom);
    end
  endtask

  initial begin
    pa = 16'hF335;
    pb = 8'hC5;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; tst[i] = 0; word[i] = '0; ebits[i] = '0; rises[i] = 0; pclk[i] = 1'b0;
    end
    set_stim(0);
    for (int e = 0; e < 1600; e++) begin
      @(posedge clk);
      #1;
      model_and_check(0, e, coa, loa, ba, dna, {16'd0, bia}, {16'd0, pa});
      model_and_check(1, e, cob, lob, bb, dnb, {24'd0, bib}, {24'd0, pb});
      set_stim(e + 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shiftin.md
# shiftin

Serial-in reader for a parallel-in/serial-out shift register chain, such as a 74HC165. It is the input-side counterpart of `shiftout`. On a start pulse it:
- pulses the active-low parallel-load line,
- clocks `WIDTH` bits in MSB first on `data_in`,
- presents the captured word on `bits_out` with a one-cycle `done_out` strobe.

It sits between board-level input shift registers and the fabric logic that consumes button and switch state.

## Interface
Parameters:
- `WIDTH`, 16: number of bits read per transfer (2..32).
- `HALF`, 1: length of each load, low and high phase, in `clk_in` cycles (≥1).

Ports:
- `clk_in`  in  1  system clock. This is the only clock; every register is on its rising edge.
- `reset_in`  in  1  synchronous, active-high reset.
- `start_in`  in  1  request a transfer. It is sampled only in IDLE.
- `data_in`  in  1  serial data from the shift register output (QH).
- `clk_out`  out  1  shift clock to the register chain.
- `load_out`  out  1  parallel load, active low (PL/SH_LD).
- `bits_out`  out  WIDTH  last completed word; the first bit read lands in the MSB.
- `busy_out`  out  1  high while a transfer is in progress.
- `done_out`  out  1  one-cycle strobe when `bits_out` has just been updated.

## Operation
- All outputs are registered.
- Reset values: `clk_out`=0, `load_out`=1, `bits_out`=0, `busy_out`=0, `done_out`=0. Reset clears the state to IDLE, and the phase and bit counters to 0.
- States: IDLE → LOAD → LOW → HIGH → LOW … → DONE → IDLE.
- IDLE:
  - Outputs: `clk_out`=0, `load_out`=1, `busy_out`=0.
  - `start_in`=1 → LOAD.
- LOAD:
  - `load_out`=0 for HALF cycles.
  - Then → LOW.
- LOW:
  - `load_out`=1, `clk_out`=0 for HALF cycles.
  - Then, if the bit counter is below WIDTH → HIGH, otherwise → DONE.
- HIGH:
  - Entered on the same edge that samples `data_in` into the shift register. The value captured is the one present before `clk_out` rises.
  - Shifting is left: `sr <= {sr[WIDTH-2:0], data_in}`. The bit counter increments on entry.
  - `clk_out`=1 for HALF cycles, then → LOW.
- DONE, one cycle:
  - `bits_out` <= sr, `done_out`=1, then → IDLE.
- Bit order: the first sampled bit ends in `bits_out[WIDTH-1]`; the last ends in `bits_out[0]`.
- Exactly WIDTH rising edges of `clk_out` per transfer.
- `bits_out` changes only in the DONE cycle, or on reset. It holds its value otherwise.
- Phase counter: counts 0..HALF-1 within each phase and wraps to 0 on every state change.
- Bit counter: width clog2(WIDTH+1). It is cleared on entry to LOAD.

## Timing
- Cycle 0 is the edge at which `start_in`=1 is sampled in IDLE.
- `load_out`=0 and `busy_out`=1 are visible from cycle 1 through cycle HALF.
- `busy_out` stays 1 through the DONE cycle inclusive.
- First low phase covers cycles HALF+1..2·HALF. Then each bit k (0-based) occupies one high phase followed by one low phase.
- Rising edge of `clk_out` for bit k is at cycle (2+2k)·HALF+1. `data_in` is sampled on the clock edge that starts this cycle.
- `done_out`=1 at cycle (2+2·WIDTH)·HALF+1. For defaults this is cycle 35.
- Earliest next accepted start is at cycle (2+2·WIDTH)·HALF+2. `start_in` during LOAD/LOW/HIGH/DONE is ignored, and is not queued.
- A level-held `start_in` gives back-to-back transfers with one IDLE cycle between them.
- Reset mid-transfer: on the next cycle the outputs take their reset values. There is no `done_out` strobe, and the partial word is discarded.
- Reset and start asserted together: reset wins.

## Test plan
- Default parameters, behavioural 74HC165 model loaded with 16'hF335, one `start_in` pulse:
  - `done_out` at cycle 35;
  - `bits_out`=16'hF335;
  - exactly 16 `clk_out` rising edges;
  - `load_out` low only in cycle 1.
- Model reloaded with 16'hAA00, second transfer → `bits_out` changes from 16'hF335 to 16'hAA00 only in the `done_out` cycle.
- `HALF`=3, `WIDTH`=8, model value 8'hC5:
  - `load_out` low in cycles 1–3;
  - first `clk_out` rise at cycle 7;
  - `done_out` at cycle 55;
  - `bits_out`=8'hC5.
- Extra `start_in` pulses at cycles 5 and 35 (DONE cycle) → ignored; a single `done_out`, and the next `load_out` low occurs only after the next start sampled in IDLE.
- `reset_in` at cycle 12 during a transfer → next cycle: `clk_out`=0, `load_out`=1, `busy_out`=0, `bits_out`=0; no `done_out`; a new start afterwards completes normally.
- `start_in` held high → back-to-back transfers:
  - second `load_out` low at cycle 37;
  - `done_out` at cycles 35 and 71.
